// File: rtl/step_motor_pkg.sv
// Shared types and constants for the stepper motor driver: FSM state, the
// half-step phase table and the H-bridge leg encoding of one coil.
package step_motor_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] MIN_PERIOD = 16'd2;

  // Coil polarity codes used inside the phase table
  localparam logic [1:0] COIL_OFF = 2'b00;
  localparam logic [1:0] COIL_POS = 2'b01;
  localparam logic [1:0] COIL_NEG = 2'b10;

  // Bridge drive as {X, Y, E}
  localparam logic [2:0] DRV_OFF = 3'b000;
  localparam logic [2:0] DRV_POS = 3'b101;
  localparam logic [2:0] DRV_NEG = 3'b011;

  // Entry i is {coil A code, coil B code} for phase index i
  localparam logic [7:0][3:0] PHASE_TABLE = {
    {COIL_POS, COIL_NEG},  // 7
    {COIL_OFF, COIL_NEG},  // 6
    {COIL_NEG, COIL_NEG},  // 5
    {COIL_NEG, COIL_OFF},  // 4
    {COIL_NEG, COIL_POS},  // 3
    {COIL_OFF, COIL_POS},  // 2
    {COIL_POS, COIL_POS},  // 1
    {COIL_POS, COIL_OFF}   // 0
  };

  function automatic logic [2:0] coil_drive(input logic [1:0] code);
    case (code)
      COIL_POS: coil_drive = DRV_POS;
      COIL_NEG: coil_drive = DRV_NEG;
      default:  coil_drive = DRV_OFF;
    endcase
  endfunction

endpackage

// File: rtl/step_motor_driver_if.sv
// Command/status bundle between a move controller (master) and the stepper
// driver (slave).
interface step_motor_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic        cmd_half;
  logic [15:0] cmd_period;
  logic        abort;
  logic        hold;
  logic        busy;
  logic        done;
  logic [15:0] position;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_period, abort, hold,
    input  cmd_ready, busy, done, position
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_period, abort, hold,
    output cmd_ready, busy, done, position
  );
endinterface

// File: rtl/step_phase_decode.sv
// Combinational decode of a 3-bit phase index into the six H-bridge signals.
module step_phase_decode
  import step_motor_pkg::*;
(
  input  logic [2:0] phase,
  output logic       ax,
  output logic       ay,
  output logic       ae,
  output logic       bx,
  output logic       by,
  output logic       be
);

  logic [3:0] entry;

  always_comb begin
    entry          = PHASE_TABLE[phase];
    {ax, ay, ae}   = coil_drive(entry[3:2]);
    {bx, by, be}   = coil_drive(entry[1:0]);
  end

endmodule

// File: rtl/step_motor_driver.sv
// Stepper motor driver: accepts a move command, emits one step every period
// cycles through a half/full-step phase table and drives two H-bridges.
module step_motor_driver
  import step_motor_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  step_motor_driver_if.slave   bus,
  output logic                 AX,
  output logic                 AY,
  output logic                 BX,
  output logic                 BY,
  output logic                 AE,
  output logic                 BE
);

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [15:0] position_q, position_d;
  logic [2:0]  phase_q, phase_d;
  logic        dir_q, dir_d;
  logic        half_q, half_d;
  logic        done_q, done_d;
  logic        zero_pend_q, zero_pend_d;
  logic [5:0]  drive_q, drive_d;

  logic [15:0] clamped_period;
  logic [2:0]  phase_inc;
  logic        dec_ax, dec_ay, dec_ae, dec_bx, dec_by, dec_be;

  // Decode looks at the next phase so the registered drive lines up with it
  step_phase_decode u_decode (
    .phase (phase_d),
    .ax    (dec_ax),
    .ay    (dec_ay),
    .ae    (dec_ae),
    .bx    (dec_bx),
    .by    (dec_by),
    .be    (dec_be)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    position_d  = position_q;
    phase_d     = phase_q;
    dir_d       = dir_q;
    half_d      = half_q;
    done_d      = 1'b0;
    zero_pend_d = 1'b0;

    clamped_period = (bus.cmd_period < MIN_PERIOD) ? MIN_PERIOD : bus.cmd_period;
    phase_inc      = half_q ? 3'd1 : 3'd2;

    case (state_q)
      ST_IDLE: begin
        // A zero-step command completes one edge after it is accepted
        done_d = zero_pend_q;
        if (bus.cmd_valid) begin
          dir_d    = bus.cmd_dir;
          half_d   = bus.cmd_half;
          period_d = clamped_period;
          cnt_d    = clamped_period - 16'd1;
          rem_d    = bus.cmd_steps;
          if (bus.cmd_steps == 16'd0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 16'd0) begin
          cnt_d      = period_q - 16'd1;
          rem_d      = rem_q - 16'd1;
          phase_d    = dir_q ? (phase_q + phase_inc) : (phase_q - phase_inc);
          position_d = dir_q ? (position_q + 16'd1) : (position_q - 16'd1);
          if (rem_q == 16'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drive_d = ((state_d == ST_RUN) || bus.hold)
            ? {dec_ax, dec_ay, dec_ae, dec_bx, dec_by, dec_be}
            : 6'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= 16'd0;
      cnt_q       <= 16'd0;
      period_q    <= 16'd0;
      position_q  <= 16'd0;
      phase_q     <= 3'd0;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      drive_q     <= 6'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      position_q  <= position_d;
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      done_q      <= done_d;
      zero_pend_q <= zero_pend_d;
      drive_q     <= drive_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.position  = position_q;
  assign {AX, AY, AE, BX, BY, BE} = drive_q;

endmodule

// File: tb/tb_step_motor_driver.sv
// Self-checking bench for step_motor_driver: directed and random moves checked
// every cycle against a timing/arithmetic model of the move.
module tb_step_motor_driver;

  logic clock = 1'b0;
  logic reset;
  logic AX, AY, BX, BY, AE, BE;

  always #5 clock = ~clock;

  step_motor_driver_if bus ();

  step_motor_driver dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .AX    (AX),
    .AY    (AY),
    .BX    (BX),
    .BY    (BY),
    .AE    (AE),
    .BE    (BE)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int model_pos   = 0;
  int model_phase = 0;

  // Coil polarity per phase index: +1, 0, -1
  int a_tab[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int b_tab[8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  function automatic logic [2:0] enc(int v);
    if (v > 0)      return 3'b101;
    else if (v < 0) return 3'b011;
    else            return 3'b000;
  endfunction

  function automatic logic [5:0] exp_drive(int ph, bit on);
    if (!on) return 6'b0;
    return {enc(a_tab[ph]), enc(b_tab[ph])};
  endfunction

  function automatic int mod8(int x);
    return ((x % 8) + 8) % 8;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag, bit busy_e, bit done_e, int pos_e, int ph_e, bit on);
    logic [15:0] pv;
    pv = pos_e[15:0];
    check_output({tag, "/busy"},  {31'b0, bus.busy}, {31'b0, busy_e});
    check_output({tag, "/ready"}, {31'b0, bus.cmd_ready}, {31'b0, !busy_e});
    check_output({tag, "/done"},  {31'b0, bus.done}, {31'b0, done_e});
    check_output({tag, "/pos"},   {16'b0, bus.position}, {16'b0, pv});
    check_output({tag, "/drive"}, {26'b0, AX, AY, AE, BX, BY, BE}, {26'b0, exp_drive(ph_e, on)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_pos   = 0;
    model_phase = 0;
  endtask

  // One move; abort_at = edge index (after accept) at which abort is sampled, 0 = none
  task automatic apply_stimulus(string tag, int steps, bit dir, bit half, int period,
                                bit hold_v, int abort_at, bit idle_abort);
    int p, endt, s, pos, ph, sgn;
    bit busy_e, done_e;
    p   = (period < 2) ? 2 : period;
    sgn = dir ? 1 : -1;
    if (steps == 0)        endt = 1;
    else if (abort_at > 0) endt = abort_at;
    else                   endt = steps * p;

    bus.hold       = hold_v;
    bus.cmd_steps  = 16'(steps);
    bus.cmd_dir    = dir;
    bus.cmd_half   = half;
    bus.cmd_period = 16'(period);
    bus.abort      = idle_abort;
    bus.cmd_valid  = 1'b1;
    check_output({tag, "/ready_pre"}, {31'b0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;

    s = 0;
    for (int t = 0; t <= endt + 1; t++) begin
      if (steps == 0) begin
        s = 0; busy_e = 0; done_e = (t == 1);
      end else if (abort_at > 0 && t >= abort_at) begin
        s = (abort_at - 1) / p; busy_e = 0; done_e = 0;
      end else begin
        s = t / p;
        if (s > steps) s = steps;
        busy_e = (t < steps * p);
        done_e = (t == steps * p);
      end
      pos = model_pos + sgn * s;
      ph  = mod8(model_phase + sgn * (half ? 1 : 2) * s);
      check_all($sformatf("%s t=%0d", tag, t), busy_e, done_e, pos, ph, busy_e || hold_v);
      if (t == endt + 1) break;
      bus.abort = (abort_at > 0) && (t + 1 == abort_at);
      if (steps > 0 && endt >= 2 && t == 1) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_steps  = 16'd7;
        bus.cmd_period = 16'd3;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    model_pos   = (model_pos + sgn * s) & 16'hFFFF;
    model_phase = mod8(model_phase + sgn * (half ? 1 : 2) * s);
  endtask

  initial begin
    int st, pd, ab;
    bit dr, hf, hd;

    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int st, pd, ab;
    bit dr, hf, hd;

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = 16'd0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_half   = 1'b0;
    bus.cmd_period = 16'd0;
    bus.abort      = 1'b0;
    bus.hold       = 1'b1;
    tick();
    tick();
    $display("[TB] reset state");
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    $display("[TB] half-step forward");
    apply_stimulus("half3", 3, 1, 1, 4, 0, 0, 0);
    check_output("half3/final_pos", {16'b0, bus.position}, 32'd3);

    $display("[TB] full-step reverse with hold");
    do_reset();
    apply_stimulus("full_rev", 2, 0, 0, 10, 1, 0, 0);
    bus.hold = 1'b0;
    tick();
    check_output("hold_off/drive", {26'b0, AX, AY, AE, BX, BY, BE}, 32'd0);
    bus.hold = 1'b1;
    tick();
    check_output("hold_on/drive", {26'b0, AX, AY, AE, BX, BY, BE}, {26'b0, 6'b011_000});

    $display("[TB] degenerate commands");
    apply_stimulus("zero_steps", 0, 1, 1, 5, 1, 0, 0);
    apply_stimulus("period0", 3, 1, 0, 0, 1, 0, 0);

    $display("[TB] abort and busy command");
    apply_stimulus("abort5", 5, 1, 1, 3, 0, 6, 0);
    apply_stimulus("abort_last", 2, 0, 1, 3, 1, 6, 0);
    apply_stimulus("idle_abort", 2, 0, 1, 2, 1, 0, 1);

    $display("[TB] position wrap");
    do_reset();
    apply_stimulus("wrap_rev", 2, 0, 0, 2, 0, 0, 0);
    apply_stimulus("wrap_fwd", 3, 1, 1, 2, 0, 0, 0);
    check_output("wrap/final_pos", {16'b0, bus.position}, 32'd1);

    $display("[TB] random moves");
    for (int i = 0; i < 12; i++) begin
      st = $urandom_range(0, 6);
      pd = $urandom_range(0, 6);
      dr = 1'($urandom_range(0, 1));
      hf = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      ab = 0;
      if (st > 0 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(2, st * ((pd < 2) ? 2 : pd));
      apply_stimulus($sformatf("rnd%0d", i), st, dr, hf, pd, hd, ab, 0);
    end

    $display("[TB] reset mid-move");
    bus.hold       = 1'b1;
    bus.cmd_steps  = 16'd5;
    bus.cmd_dir    = 1'b1;
    bus.cmd_half   = 1'b1;
    bus.cmd_period = 16'd3;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check_output("pre_reset/busy", {31'b0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all("in_reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    model_pos   = 0;
    model_phase = 0;
    tick();
    check_all("post_reset", 0, 0, 0, 0, 1);
    tick();
    check_all("post_reset2", 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/step_motor_driver.md
STEP_MOTOR_DRIVER -- requirements
Module: step_motor_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clock`  in  1  -- the single clock; all state changes on its rising edge.
REQ-003 Port `reset`  in  1  -- asynchronous, active-high reset.
REQ-004 Port `cmd_valid`  in  1  -- move command offered.
REQ-005 Port `cmd_ready`  out  1  -- high in IDLE only; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-006 Port `cmd_steps`  in  16  -- number of steps to move; unsigned.
REQ-007 Port `cmd_dir`  in  1  -- step direction; 1 = forward (+), 0 = reverse (-).
REQ-008 Port `cmd_half`  in  1  -- step mode; 1 = half-step, 0 = full-step.
REQ-009 Port `cmd_period`  in  16  -- clock cycles per step; values below 2 are treated as 2.
REQ-010 Port `abort`  in  1  -- stop the current move.
REQ-011 Port `hold`  in  1  -- 1 = keep the coils energised while idle.
REQ-012 Port `busy`  out  1  -- high while in RUN.
REQ-013 Port `done`  out  1  -- one-cycle pulse when a move completes.
REQ-014 Port `position`  out  16  -- signed step counter; wraps modulo 2^16.
REQ-015 Port `AX`, `AY`, `BX`, `BY`, `AE`, `BE`  out  1 each  -- H-bridge drive signals for coil A and coil B (X/Y = bridge legs, E = enable).

Function
REQ-016 The block SHALL implement a state machine with two states, IDLE and RUN; it leaves reset in IDLE.
REQ-017 Accepting a command SHALL:
- latch steps, dir, half and the clamped period;
- load the period counter with period-1;
- enter RUN.
REQ-018 A command with cmd_steps=0 SHALL be accepted, SHALL NOT move the motor, and SHALL pulse done on the edge after acceptance while staying in IDLE.
REQ-019 In RUN, the period counter SHALL decrement every cycle. When it reaches 0, the block SHALL, on that edge:
- advance the phase index by ±1 (half-step) or ±2 (full-step), modulo 8;
- add ±1 to position;
- decrement the remaining step count;
- reload the counter with period-1.
REQ-020 The first step SHALL take effect exactly cmd_period cycles after the accept edge, and each following step cmd_period cycles after the previous one.
REQ-021 On the edge that performs the last step, the block SHALL return to IDLE and assert done for one cycle.
REQ-022 Coil drive per phase index 0..7:
- coil A: +,+,0,-,-,-,0,+
- coil B: 0,+,+,+,0,-,-,-
REQ-023 Coil encoding SHALL be:
- "+" = X1 Y0 E1
- "-" = X0 Y1 E1
- "0" = X0 Y0 E0
REQ-024 The drive outputs SHALL be registered: they reflect the phase index in RUN, and in IDLE when hold=1; in IDLE with hold=0 all six SHALL be 0.
REQ-025 The phase index and position SHALL be retained between moves.
REQ-026 abort in RUN SHALL force IDLE on the next edge, without a step on that edge and without done, even if that edge would have been the last step.
REQ-027 abort in IDLE SHALL be ignored, including when cmd_valid is high in the same cycle, in which case the command is accepted.
REQ-028 cmd_valid while busy SHALL be ignored (cmd_ready=0).
REQ-029 X and Y of the same coil SHALL never both be 1.

Reset
REQ-030 While reset is asserted, the block SHALL force:
- state=IDLE;
- phase index=0, position=0, counters=0;
- AX, AY, BX, BY, AE, BE, busy and done = 0;
- cmd_ready=1.
REQ-031 Reset asserted mid-move SHALL abandon the move immediately without a done pulse; after release, the outputs follow REQ-024.

Structure
REQ-032 A shared package `step_motor_pkg` SHALL hold:
- the state enum;
- the 8-entry phase table;
- the coil encoding constants;
- the minimum-period constant (2).
REQ-033 The index-to-six-signal decode SHALL be a combinational sub-module, `step_phase_decode`, instanced once, with its outputs registered in the parent.

Verification
REQ-034 Half-step: steps=3, dir=1, half=1, period=4, hold=0, from reset → steps at +4, +8 and +12 cycles after accept; phase index 1, 2, 3; done at +12; position=3; outputs 0 afterwards.
REQ-035 Full-step reverse: steps=2, dir=0, half=0, period=10, hold=1, starting from index 0 → index 6 then 4; position=-2; outputs hold A-/B0 (X0 Y1 E1 / 0 0 0) in IDLE.
REQ-036 Degenerate commands: steps=0 → done one cycle after accept, no output change. period=0 → steps spaced 2 cycles apart.
REQ-037 Abort: abort asserted on the cycle before the 2nd of 5 steps → IDLE, position=1, no done; a cmd_valid issued while busy is not accepted.
REQ-038 Wrap and reset: 65535 steps forward, then 2 more → position wraps to 1. Async reset mid-move → outputs 0 within the reset cycle, no done.
